// File: rtl/data_mem_controller.sv
// data_mem_controller
//
// MEM-stage data memory controller. It turns a MEM-stage load/store into a
// registered request to a memory that answers with a one-cycle Ready pulse.
// While the access is outstanding it stalls the pipeline. It also handles
// big-endian sub-word lane steering, load extension and misalignment
// exceptions.
//
// Configuration macro:
//   DATA_MEM_LLSC_EN : when defined, LL/SC use a link bit and a link address.
//                      When undefined, LL behaves as LW, and SC always writes
//                      and reports success (DataOut = 1).
//
// Ports:
//   clock, reset           : single clock; synchronous active-high reset
//   Address, DataIn        : MEM-stage byte address and forwarded store data
//   MemRead, MemWrite      : MEM-stage load / store
//   MemSize                : 00 word, 01 half, 10 byte, 11 word
//   SignExtend             : sign-extend (1) or zero-extend (0) sub-word loads
//   LLSC                   : load is LL, store is SC
//   Eret                   : clears the LL link bit
//   M_Exception_Stall      : MEM instruction is being flushed (no new access)
//   M_Stall                : global MEM-stage stall from the hazard unit
//   DataMem_In/_Ready      : memory read data and completion pulse
//   DataOut                : load result or SC status to WB
//   M_Stall_Controller     : stall request to the hazard unit
//   EXC_AdEL / EXC_AdES    : misaligned load / store (combinational)
//   DataMem_Read/_Write    : registered read request / byte enables (bit 3 = offset 0)
//   DataMem_Address/_Out   : registered word address and lane-replicated store data
module data_mem_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        SignExtend,
  input  logic        LLSC,
  input  logic        Eret,
  input  logic        M_Exception_Stall,
  input  logic        M_Stall,
  input  logic [31:0] DataMem_In,
  input  logic        DataMem_Ready,
  output logic [31:0] DataOut,
  output logic        M_Stall_Controller,
  output logic        EXC_AdEL,
  output logic        EXC_AdES,
  output logic        DataMem_Read,
  output logic [3:0]  DataMem_Write,
  output logic [29:0] DataMem_Address,
  output logic [31:0] DataMem_Out
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t      stateQ, stateD;
  logic        readQ, readD;
  logic [3:0]  writeQ, writeD;
  logic [29:0] addrQ, addrD;
  logic [31:0] outQ, outD;
  logic [31:0] dataQ, dataD;

  logic        aligned, validOp, scFail;
  logic [3:0]  byteEn;
  logic [31:0] storeData, loadData;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  // Alignment: reserved size 11 is treated as a word access.
  always_comb begin
    case (MemSize)
      2'b01:   aligned = ~Address[0];
      2'b10:   aligned = 1'b1;
      default: aligned = (Address[1:0] == 2'b00);
    endcase
  end

  assign validOp  = (MemRead | MemWrite) & aligned & ~M_Exception_Stall;
  assign EXC_AdEL = MemRead & ~aligned;
  assign EXC_AdES = MemWrite & ~aligned;

  // Big-endian lane steering: byte offset 0 lives in bits [31:24] / enable bit 3.
  always_comb begin
    case (MemSize)
      2'b01: begin
        byteEn    = Address[1] ? 4'b0011 : 4'b1100;
        storeData = {2{DataIn[15:0]}};
      end
      2'b10: begin
        byteEn    = 4'b1000 >> Address[1:0];
        storeData = {4{DataIn[7:0]}};
      end
      default: begin
        byteEn    = 4'b1111;
        storeData = DataIn;
      end
    endcase
  end

  always_comb begin
    case (Address[1:0])
      2'b00:   loadByte = DataMem_In[31:24];
      2'b01:   loadByte = DataMem_In[23:16];
      2'b10:   loadByte = DataMem_In[15:8];
      default: loadByte = DataMem_In[7:0];
    endcase
    loadHalf = Address[1] ? DataMem_In[15:0] : DataMem_In[31:16];
    case (MemSize)
      2'b01:   loadData = {{16{SignExtend & loadHalf[15]}}, loadHalf};
      2'b10:   loadData = {{24{SignExtend & loadByte[7]}}, loadByte};
      default: loadData = DataMem_In;
    endcase
  end

`ifdef DATA_MEM_LLSC_EN
  logic        linkQ, linkD;
  logic [29:0] linkAddrQ, linkAddrD;

  // A failing SC never reaches memory; it only reports 0 through HOLD.
  assign scFail = MemWrite & LLSC & ~(linkQ & (linkAddrQ == Address[31:2]));

  // Link tracking: LL completion sets it, any SC or Eret clears it, and Eret wins.
  always_comb begin
    linkD     = linkQ;
    linkAddrD = linkAddrQ;
    if (stateQ == IDLE && validOp && MemWrite && LLSC) begin
      linkD = 1'b0;
    end
    if (stateQ == ACCESS && DataMem_Ready && readQ && LLSC) begin
      linkD     = 1'b1;
      linkAddrD = addrQ;
    end
    if (Eret) begin
      linkD = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      linkQ     <= 1'b0;
      linkAddrQ <= '0;
    end else begin
      linkQ     <= linkD;
      linkAddrQ <= linkAddrD;
    end
  end
`else
  assign scFail = 1'b0;
`endif

  // The stall request depends only on the state and the MEM inputs, never on
  // M_Stall, so it cannot form a loop through the hazard unit.
  always_comb begin
    stateD             = stateQ;
    readD              = readQ;
    writeD             = writeQ;
    addrD              = addrQ;
    outD               = outQ;
    dataD              = dataQ;
    M_Stall_Controller = 1'b0;
    case (stateQ)
      IDLE: begin
        if (validOp) begin
          M_Stall_Controller = 1'b1;
          if (scFail) begin
            stateD = HOLD;
            dataD  = 32'd0;
          end else begin
            stateD = ACCESS;
            readD  = MemRead;
            writeD = MemWrite ? byteEn : 4'b0000;
            addrD  = Address[31:2];
            outD   = storeData;
          end
        end
      end
      ACCESS: begin
        // Once issued, an access always completes, even if a flush arrives.
        M_Stall_Controller = 1'b1;
        if (DataMem_Ready) begin
          stateD = HOLD;
          readD  = 1'b0;
          writeD = 4'b0000;
          if (readQ) begin
            dataD = loadData;
          end else if (LLSC) begin
            dataD = 32'd1;
          end
        end
      end
      HOLD: begin
        // Wait out an external stall so the same op is not issued twice.
        if (!M_Stall) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= IDLE;
      readQ  <= 1'b0;
      writeQ <= 4'b0000;
      addrQ  <= '0;
      outQ   <= '0;
      dataQ  <= '0;
    end else begin
      stateQ <= stateD;
      readQ  <= readD;
      writeQ <= writeD;
      addrQ  <= addrD;
      outQ   <= outD;
      dataQ  <= dataD;
    end
  end

  assign DataOut         = dataQ;
  assign DataMem_Read    = readQ;
  assign DataMem_Write   = writeQ;
  assign DataMem_Address = addrQ;
  assign DataMem_Out     = outQ;

endmodule

// File: doc/data_mem_controller.md
DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

Interface
REQ-001 clock  in  1  single clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 Address  in  32  MEM-stage byte address.
REQ-004 DataIn  in  32  MEM-stage store data, already forwarded.
REQ-005 MemRead  in  1  MEM-stage load.
REQ-006 MemWrite  in  1  MEM-stage store.
REQ-007 MemSize  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
REQ-008 SignExtend  in  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-009 LLSC  in  1  load = LL, store = SC.
REQ-010 Eret  in  1  clears the LL link bit.
REQ-011 M_Exception_Stall  in  1  MEM instruction is being flushed; suppresses new accesses.
REQ-012 M_Stall  in  1  global MEM-stage stall from the hazard unit.
REQ-013 DataMem_In  in  32  read data from memory.
REQ-014 DataMem_Ready  in  1  memory completion, one-cycle pulse.
REQ-015 DataOut  out  32  load result or SC status to WB.
REQ-016 M_Stall_Controller  out  1  controller stall request to the hazard unit.
REQ-017 EXC_AdEL  out  1  misaligned load (combinational).
REQ-018 EXC_AdES  out  1  misaligned store (combinational).
REQ-019 DataMem_Read  out  1  registered read request.
REQ-020 DataMem_Write  out  4  registered byte enables; bit 3 = address offset 0 (big-endian).
REQ-021 DataMem_Address  out  30  registered word address, Address[31:2].
REQ-022 DataMem_Out  out  32  registered store data, sub-word data replicated across lanes.

Function
REQ-023 A valid op SHALL be (MemRead|MemWrite) & aligned & ~M_Exception_Stall.
- Aligned: word needs Address[1:0]=0; half needs Address[0]=0; byte is always aligned.
REQ-024 A misaligned op SHALL assert EXC_AdEL (read) or EXC_AdES (write) in the same cycle, issue no request and assert no stall.
REQ-025 The FSM SHALL have states IDLE, ACCESS and HOLD.
- IDLE: on a valid op, M_Stall_Controller=1 combinationally, request registers load, next state ACCESS.
REQ-026 ACCESS SHALL hold DataMem_Read/DataMem_Write and M_Stall_Controller=1 until DataMem_Ready=1, then latch the read data and go to HOLD.
REQ-027 HOLD SHALL deassert M_Stall_Controller and the requests and drive DataOut from the latch.
- Stay in HOLD while M_Stall=1; otherwise go to IDLE.
- No op is re-issued while the pipeline is held by IF.
REQ-028 Minimum penalty SHALL be 2 stall cycles: op enters MEM at t, request at t+1, Ready at t+1, stall released at t+2.
REQ-029 M_Stall_Controller SHALL depend only on state and MEM inputs, never on M_Stall, so no combinational loop forms.
REQ-030 Asserting M_Exception_Stall during ACCESS SHALL NOT abort the access; it completes normally.
REQ-031 Byte enables SHALL be: byte = 1000>>Address[1:0]; half = 1100 (offset 0) or 0011 (offset 2); word = 1111.
REQ-032 Load extraction SHALL be big-endian: byte offset 0 maps to bits [31:24], with 8/16-bit sign or zero extension per SignExtend.
REQ-033 LL SHALL, on completion, set the link bit and latch Address[31:2].
REQ-034 SC SHALL succeed only when the link bit is set and the latched address equals Address[31:2].
- Success: perform the write, DataOut=1.
- Failure: no memory request, one stall cycle (IDLE->HOLD directly), DataOut=0.
- Any SC clears the link bit.
REQ-035 The link bit SHALL clear on Eret, and Eret SHALL take priority over a simultaneous LL set.

Reset
REQ-036 reset SHALL force IDLE and clear the link bit, the latches and all outputs to 0 on the next edge.
- Applies even during ACCESS; any pending request is dropped.
REQ-037 The first op after reset SHALL be accepted in the cycle following reset deassertion.

Configuration
REQ-038 With macro DATA_MEM_LLSC_EN defined, REQ-033..035 SHALL be implemented.
REQ-039 Without DATA_MEM_LLSC_EN, LLSC SHALL be ignored for loads (LL acts as LW), and SC SHALL always write and return DataOut=1; no link state exists.

Verification
REQ-040 LW at 0x100, memory returns 0xDEADBEEF with Ready at t+1 -> stall at t and t+1, DataOut=0xDEADBEEF, DataMem_Address=0x40.
REQ-041 LB SignExtend=1 at 0x203, data 0x112233F4 -> DataOut=0xFFFFFFF4; SB at 0x201 with DataIn=0x000000AB -> DataMem_Write=0100, DataMem_Out=0xABABABAB.
REQ-042 LH at 0x102 -> EXC_AdEL=0; LW at 0x102 -> EXC_AdEL=1, no DataMem_Read, M_Stall_Controller=0.
REQ-043 LL at 0x300, then SC at 0x300 -> write occurs, DataOut=1; repeat SC -> no write, DataOut=0; LL, Eret, SC -> DataOut=0.
REQ-044 Load completes while M_Stall=1 for 3 cycles -> FSM stays in HOLD, exactly one DataMem_Read sequence, DataOut stable.
REQ-045 reset asserted mid-ACCESS -> next cycle IDLE, DataMem_Read=0, all outputs 0.
